// File: rtl/nonce_sweep_scheduler.sv
// Nonce sweep scheduler: hands consecutive nonces to a pool of SHA-256 engines,
// latches the first hash word 0 below target, and reports one result per sweep.
// Optional completed-hash counter on stat_hashes when SCHED_STATS_EN is defined.
module nonce_sweep_scheduler #(
  parameter int unsigned NUM_ENG = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_base,
  input  logic [31:0]            cmd_count,
  input  logic [31:0]            cmd_target,
  input  logic                   abort,
  output logic [NUM_ENG-1:0]     eng_start,
  output logic [31:0]            eng_nonce,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [32*NUM_ENG-1:0]  eng_hash0,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_found,
  output logic                   res_aborted,
  output logic [31:0]            res_nonce,
  output logic                   busy,
  output logic [31:0]            stat_hashes
);

  localparam int unsigned IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_REPORT   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          nonce_q, rem_q, target_q;
  logic [NUM_ENG-1:0]   eng_busy_q;
  logic [31:0]          slot_nonce_q [NUM_ENG];

  logic [NUM_ENG-1:0]   done_acc_c, hit_vec_c, start_vec_c;
  logic [IDX_W-1:0]     hit_sel_c, free_sel_c;
  logic                 hit_any_c, free_any_c, hit_take_c, dispatch_c, accept_c;

  // Accepted completions, hits and lowest-index free/hit engine selection
  always_comb begin
    done_acc_c = eng_done & eng_busy_q;
    hit_vec_c  = '0;
    for (int i = 0; i < int'(NUM_ENG); i++) begin
      if (done_acc_c[i] && (eng_hash0[i*32 +: 32] < target_q)) hit_vec_c[i] = 1'b1;
    end
    hit_any_c  = 1'b0;
    hit_sel_c  = '0;
    free_any_c = 1'b0;
    free_sel_c = '0;
    for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
      if (hit_vec_c[i]) begin
        hit_any_c = 1'b1;
        hit_sel_c = IDX_W'(i);
      end
      if (!eng_busy_q[i]) begin
        free_any_c = 1'b1;
        free_sel_c = IDX_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cmd_valid) state_d = (cmd_count == 32'd0) ? S_REPORT : S_DISPATCH;
      S_DISPATCH: if (hit_take_c || abort || (dispatch_c && rem_q == 32'd1)) state_d = S_DRAIN;
      S_DRAIN:    if ((eng_busy_q & ~done_acc_c) == '0) state_d = S_REPORT;
      S_REPORT:   if (res_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Per-cycle control decisions: accept, first-hit capture, single dispatch
  always_comb begin
    accept_c    = (state_q == S_IDLE) && cmd_valid;
    hit_take_c  = hit_any_c && !res_found && !res_aborted &&
                  ((state_q == S_DISPATCH) || (state_q == S_DRAIN));
    dispatch_c  = (state_q == S_DISPATCH) && !hit_take_c && !abort &&
                  free_any_c && (rem_q != 32'd0);
    start_vec_c = '0;
    if (dispatch_c) start_vec_c[free_sel_c] = 1'b1;
  end

  // Registered outputs, engine bookkeeping and sweep datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_found   <= 1'b0;
      res_aborted <= 1'b0;
      res_nonce   <= '0;
      eng_start   <= '0;
      eng_nonce   <= '0;
      eng_busy_q  <= '0;
      nonce_q     <= '0;
      rem_q       <= '0;
      target_q    <= '0;
      for (int i = 0; i < int'(NUM_ENG); i++) slot_nonce_q[i] <= '0;
    end else begin
      cmd_ready  <= (state_d == S_IDLE);
      busy       <= (state_d != S_IDLE);
      res_valid  <= (state_d == S_REPORT);
      eng_start  <= start_vec_c;
      eng_busy_q <= (eng_busy_q & ~done_acc_c) | start_vec_c;
      if (accept_c) begin
        nonce_q     <= cmd_base;
        rem_q       <= cmd_count;
        target_q    <= cmd_target;
        res_found   <= 1'b0;
        res_aborted <= 1'b0;
        res_nonce   <= '0;
      end
      if (dispatch_c) begin
        eng_nonce                <= nonce_q;
        slot_nonce_q[free_sel_c] <= nonce_q;
        nonce_q                  <= nonce_q + 32'd1;
        rem_q                    <= rem_q - 32'd1;
      end
      if (hit_take_c) begin
        res_found <= 1'b1;
        res_nonce <= slot_nonce_q[hit_sel_c];
      end else if ((state_q == S_DISPATCH) && abort) begin
        res_aborted <= 1'b1;
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [32:0] stat_sum_c;

  // Saturating sum of accepted completions this cycle
  always_comb begin
    stat_sum_c = {1'b0, stat_hashes};
    for (int i = 0; i < int'(NUM_ENG); i++) stat_sum_c = stat_sum_c + 33'(done_acc_c[i]);
  end

  // Completed-hash counter, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          stat_hashes <= '0;
    else if (stat_sum_c[32]) stat_hashes <= 32'hFFFF_FFFF;
    else                   stat_hashes <= stat_sum_c[31:0];
  end
`else
  assign stat_hashes = 32'd0;
`endif

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Directed bench for nonce_sweep_scheduler with a latency/hash engine model.
// Honors SCHED_STATS_EN for the expected stat_hashes value.
module tb_nonce_sweep_scheduler;

  localparam int unsigned NE = 4;
`ifdef SCHED_STATS_EN
  localparam logic [31:0] STAT_EXP = 32'd8;
`else
  localparam logic [31:0] STAT_EXP = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cmd_valid, cmd_ready, abort;
  logic [31:0]     cmd_base, cmd_count, cmd_target;
  logic [NE-1:0]   eng_start, eng_done;
  logic [31:0]     eng_nonce;
  logic [32*NE-1:0] eng_hash0;
  logic            res_valid, res_ready, res_found, res_aborted, busy;
  logic [31:0]     res_nonce, stat_hashes;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] hash_v [NE];
  int unsigned lat [NE];
  int unsigned cnt [NE];
  logic [31:0] tgt;
  logic [31:0] st_q [$];
  bit          hit_seen;
  int          starts_after_hit;
  int          multi_start;

  nonce_sweep_scheduler #(.NUM_ENG(NE)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_target(cmd_target),
    .abort(abort),
    .eng_start(eng_start), .eng_nonce(eng_nonce),
    .eng_done(eng_done), .eng_hash0(eng_hash0),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_aborted(res_aborted), .res_nonce(res_nonce),
    .busy(busy), .stat_hashes(stat_hashes)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NE); i++) eng_hash0[i*32 +: 32] = hash_v[i];
  end

  // Engine model and start monitor, evaluated away from the active edge
  always @(negedge clk) begin
    int nb;
    nb = 0;
    for (int i = 0; i < int'(NE); i++) begin
      if (eng_start[i]) begin
        nb++;
        st_q.push_back(eng_nonce);
        if (hit_seen) starts_after_hit++;
      end
    end
    if (nb > 1) multi_start++;
    eng_done = '0;
    for (int i = 0; i < int'(NE); i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          eng_done[i] = 1'b1;
          if (hash_v[i] < tgt) hit_seen = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(NE); i++) if (eng_start[i]) cnt[i] = lat[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] b, input logic [31:0] c, input logic [31:0] t);
    @(negedge clk);
    st_q.delete();
    hit_seen = 1'b0;
    starts_after_hit = 0;
    tgt = t;
    cmd_base = b; cmd_count = c; cmd_target = t; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic take_res(input string tag);
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    check({tag, "_rv_low"}, 32'(res_valid), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic set_engines(input logic [31:0] h0, h1, h2, h3, input int unsigned l0, l1, l2, l3);
    hash_v[0] = h0; hash_v[1] = h1; hash_v[2] = h2; hash_v[3] = h3;
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit idle_ok;
    logic [31:0] wrap_exp [4];
    reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cmd_base = '0; cmd_count = '0; cmd_target = '0; tgt = '0;
    eng_done = '0; hit_seen = 1'b0; starts_after_hit = 0; multi_start = 0;
    for (int i = 0; i < int'(NE); i++) cnt[i] = 0;
    set_engines(32'd0, 32'd0, 32'd0, 32'd0, 20, 20, 20, 20);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_nonce", eng_nonce, 32'd0);
    check("rst_res_nonce", res_nonce, 32'd0);
    check("rst_stat", stat_hashes, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Plain sweep, target 0 never hits
    send_cmd(32'h10, 32'd8, 32'd0);
    check("sw_busy", 32'(busy), 32'd1);
    check("sw_cmd_ready", 32'(cmd_ready), 32'd0);
    wait_res("sw_report", 200, cyc);
    check("sw_nstart", 32'(st_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < st_q.size(); k++) check($sformatf("sw_nonce%0d", k), st_q[k], 32'h10 + 32'(k));
    check("sw_found", 32'(res_found), 32'd0);
    check("sw_aborted", 32'(res_aborted), 32'd0);
    check("sw_res_nonce", res_nonce, 32'd0);
    check("sw_stat", stat_hashes, STAT_EXP);
    take_res("sw");

    // Nonce wrap
    send_cmd(32'hFFFF_FFFE, 32'd4, 32'd0);
    wait_res("wr_report", 200, cyc);
    wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;
    check("wr_nstart", 32'(st_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < st_q.size(); k++) check($sformatf("wr_nonce%0d", k), st_q[k], wrap_exp[k]);
    check("wr_found", 32'(res_found), 32'd0);
    take_res("wr");

    // Engines 1 and 2 hit in the same cycle; engine 1 wins
    set_engines(32'hFFFF_FFFF, 32'd5, 32'd7, 32'hFFFF_FFFF, 10, 12, 11, 20);
    send_cmd(32'h100, 32'd100, 32'h1000);
    wait_res("hit_report", 300, cyc);
    idle_ok = 1'b1;
    for (int i = 0; i < int'(NE); i++) if (cnt[i] != 0) idle_ok = 1'b0;
    check("hit_drained", 32'(idle_ok), 32'd1);
    check("hit_found", 32'(res_found), 32'd1);
    check("hit_nonce", res_nonce, 32'h101);
    check("hit_aborted", 32'(res_aborted), 32'd0);
    check("hit_late_starts", 32'(starts_after_hit), 32'd0);
    check("hit_nstart", 32'(st_q.size()), 32'd5);
    take_res("hit");

    // Zero-count sweep and result hold under backpressure
    set_engines(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 20, 20, 20);
    send_cmd(32'h55, 32'd0, 32'hFFFF_FFFF);
    wait_res("c0_report", 10, cyc);
    check("c0_latency", 32'(cyc <= 2), 32'd1);
    repeat (5) @(negedge clk);
    check("c0_hold_valid", 32'(res_valid), 32'd1);
    check("c0_hold_found", 32'(res_found), 32'd0);
    check("c0_hold_nonce", res_nonce, 32'd0);
    check("c0_nstart", 32'(st_q.size()), 32'd0);
    take_res("c0");

    // Abort three cycles into a long sweep
    send_cmd(32'h200, 32'd100, 32'h10);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_res("ab_report", 200, cyc);
    check("ab_nstart", 32'(st_q.size()), 32'd3);
    check("ab_aborted", 32'(res_aborted), 32'd1);
    check("ab_found", 32'(res_found), 32'd0);
    check("ab_nonce", res_nonce, 32'd0);
    take_res("ab");

    // Reset while draining; stale completions must be ignored
    send_cmd(32'h300, 32'd100, 32'h10);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check("rd_in_drain", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rd_busy", 32'(busy), 32'd0);
    check("rd_eng_start", 32'(eng_start), 32'd0);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    check("rd_post_busy", 32'(busy), 32'd0);
    check("rd_post_valid", 32'(res_valid), 32'd0);
    check("rd_post_ready", 32'(cmd_ready), 32'd1);
    check("rd_post_stat", stat_hashes, 32'd0);
    check("onehot_starts", 32'(multi_start), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
